// File: rtl/ring_counter_monitor.sv
// Receive-side monitor for an N-bit one-hot ring code: validates each sample,
// checks the rotate-right step sequence, decodes the index and tracks lock.
module ring_counter_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     ring_in,
  input  logic             clr_err,
  output logic [IW-1:0]    index,
  output logic             onehot_ok,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // Only meaningful for one-hot input; OR-reduction keeps it mux-free.
  function automatic logic [IW-1:0] encode(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r = r | (v[i] ? IW'(i) : '0);
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [GW-1:0]    good_q, good_d;
  logic [IW-1:0]    index_q, index_d;
  logic             onehot_q, onehot_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic             valid_s;
  logic             match_s;
  logic             lock_err_s;
  logic [N-1:0]     exp_s;
  logic [GW-1:0]    good_inc_s;

  assign valid_s    = is_onehot(ring_in);
  assign exp_s      = {prev_q[0], prev_q[N-1:1]};
  assign match_s    = (ring_in == exp_s);
  assign good_inc_s = good_q + GW'(1);

  // Next-state, datapath and lock FSM decisions.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    index_d    = index_q;
    onehot_d   = onehot_q;
    lock_err_s = 1'b0;

    if (en) begin
      onehot_d = valid_s;
      if (valid_s) begin
        prev_d  = ring_in;
        index_d = encode(ring_in);
      end else begin
        prev_d  = prev_q;
        index_d = index_q;
      end

      case (state_q)
        ST_UNLOCKED: begin
          if (valid_s) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_ACQUIRE: begin
          if (!valid_s) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
          end else if (match_s) begin
            if (good_inc_s == GW'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d  = good_inc_s;
            end
          end else begin
            // Wrong step: reseed the sequence from this sample.
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if (valid_s && match_s) begin
            state_d = ST_LOCKED;
          end else begin
            state_d    = ST_UNLOCKED;
            good_d     = '0;
            lock_err_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          good_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    step_err_d = lock_err_s;

    if (clr_err) begin
      err_d = '0;
    end else if (lock_err_s && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      prev_q     <= '0;
      good_q     <= '0;
      index_q    <= '0;
      onehot_q   <= 1'b0;
      step_err_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      index_q    <= index_d;
      onehot_q   <= onehot_d;
      step_err_q <= step_err_d;
      err_q      <= err_d;
    end
  end

  assign index     = index_q;
  assign onehot_ok = onehot_q;
  assign locked    = (state_q == ST_LOCKED);
  assign step_err  = step_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Directed bench for ring_counter_monitor (N=4, LOCK_CNT=3, ERR_W=8).
module tb_ring_counter_monitor;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] ring_in;
  logic       clr_err;
  logic [1:0] index;
  logic       onehot_ok;
  logic       locked;
  logic       step_err;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  ring_counter_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ring_in(ring_in), .clr_err(clr_err),
    .index(index), .onehot_ok(onehot_ok), .locked(locked),
    .step_err(step_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic e, input logic [3:0] r, input logic c);
    @(negedge clk);
    en = e; ring_in = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic relock();
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0100, 1'b0);
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; ring_in = 4'b0000; clr_err = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({index, onehot_ok, locked, step_err, err_count} !== 13'd0) begin
      failures++;
      $display("FAIL reset_async idx=%0d ok=%0b lk=%0b se=%0b ec=%0d expected all 0",
               index, onehot_ok, locked, step_err, err_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'b1000, 1'b0);
    drive(1'b0, 4'b1000, 1'b0);
    checks++;
    if ({index, onehot_ok, locked, step_err, err_count} !== 13'd0) begin
      failures++;
      $display("FAIL en_low_hold idx=%0d ok=%0b lk=%0b expected all 0", index, onehot_ok, locked);
    end
  endtask

  task automatic test_lock();
    logic [3:0] seq [4];
    logic [1:0] eidx [4];
    logic       elk [4];
    seq  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    eidx = '{2'd3, 2'd2, 2'd1, 2'd0};
    elk  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0);
      checks++;
      if (index !== eidx[i] || onehot_ok !== 1'b1 || locked !== elk[i]) begin
        failures++;
        $display("FAIL lock_seq%0d idx=%0d ok=%0b lk=%0b expected idx=%0d ok=1 lk=%0b",
                 i, index, onehot_ok, locked, eidx[i], elk[i]);
      end
    end
  endtask

  task automatic test_wrap_hold();
    drive(1'b1, 4'b1000, 1'b0);
    checks++;
    if (locked !== 1'b1 || index !== 2'd3 || step_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap lk=%0b idx=%0d se=%0b expected lk=1 idx=3 se=0", locked, index, step_err);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0110, 1'b0);
      checks++;
      if (locked !== 1'b1 || index !== 2'd3 || onehot_ok !== 1'b1) begin
        failures++;
        $display("FAIL hold%0d lk=%0b idx=%0d ok=%0b expected lk=1 idx=3 ok=1", i, locked, index, onehot_ok);
      end
    end
    drive(1'b1, 4'b0100, 1'b0);
    checks++;
    if (locked !== 1'b1 || index !== 2'd2 || step_err !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL after_hold lk=%0b idx=%0d se=%0b ec=%0d expected lk=1 idx=2 se=0 ec=0",
               locked, index, step_err, err_count);
    end
  endtask

  task automatic test_locked_errors();
    drive(1'b1, 4'b0001, 1'b0);
    checks++;
    if (step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || index !== 2'd0) begin
      failures++;
      $display("FAIL skip_err se=%0b ec=%0d lk=%0b idx=%0d expected se=1 ec=1 lk=0 idx=0",
               step_err, err_count, locked, index);
    end
    drive(1'b0, 4'b0000, 1'b0);
    checks++;
    if (step_err !== 1'b0) begin
      failures++;
      $display("FAIL pulse_width se=%0b expected 0", step_err);
    end
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0100, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL relock lk=%0b expected 1", locked);
    end
    drive(1'b1, 4'b0110, 1'b0);
    checks++;
    if (step_err !== 1'b1 || err_count !== 8'd2 || onehot_ok !== 1'b0 || index !== 2'd2 || locked !== 1'b0) begin
      failures++;
      $display("FAIL multi_hot se=%0b ec=%0d ok=%0b idx=%0d lk=%0b expected se=1 ec=2 ok=0 idx=2 lk=0",
               step_err, err_count, onehot_ok, index, locked);
    end
  endtask

  task automatic test_acquire();
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0010, 1'b0);
    checks++;
    if (locked !== 1'b0 || step_err !== 1'b0 || err_count !== 8'd2) begin
      failures++;
      $display("FAIL reseed lk=%0b se=%0b ec=%0d expected lk=0 se=0 ec=2", locked, step_err, err_count);
    end
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reseed_early lk=%0b expected 0", locked);
    end
    drive(1'b1, 4'b0100, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL reseed_lock lk=%0b expected 1", locked);
    end
    drive(1'b1, 4'b0000, 1'b0);
    checks++;
    if (step_err !== 1'b1 || err_count !== 8'd3) begin
      failures++;
      $display("FAIL zero_locked se=%0b ec=%0d expected se=1 ec=3", step_err, err_count);
    end
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    checks++;
    if (step_err !== 1'b0 || err_count !== 8'd3 || locked !== 1'b0 || onehot_ok !== 1'b0) begin
      failures++;
      $display("FAIL zero_acquire se=%0b ec=%0d lk=%0b ok=%0b expected se=0 ec=3 lk=0 ok=0",
               step_err, err_count, locked, onehot_ok);
    end
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b0100, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL unlock_restart lk=%0b expected 0", locked);
    end
    drive(1'b1, 4'b0010, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL unlock_relock lk=%0b expected 1", locked);
    end
  endtask

  task automatic test_counter_edges();
    int guard;
    guard = 0;
    while (err_count < 8'd255 && guard < 300) begin
      drive(1'b1, 4'b0000, 1'b0);
      relock();
      guard++;
    end
    checks++;
    if (err_count !== 8'd255 || guard !== 252) begin
      failures++;
      $display("FAIL fill_count ec=%0d iters=%0d expected ec=255 iters=252", err_count, guard);
    end
    drive(1'b1, 4'b0000, 1'b0);
    checks++;
    if (err_count !== 8'd255 || step_err !== 1'b1) begin
      failures++;
      $display("FAIL saturate ec=%0d se=%0b expected ec=255 se=1", err_count, step_err);
    end
    relock();
    drive(1'b1, 4'b0000, 1'b1);
    checks++;
    if (err_count !== 8'd0 || step_err !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL clr_priority ec=%0d se=%0b lk=%0b expected ec=0 se=1 lk=0", err_count, step_err, locked);
    end
    relock();
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("FAIL clr_no_en ec=%0d expected 0", err_count);
    end
    clr_err = 1'b0;
    drive(1'b1, 4'b0000, 1'b0);
    relock();
    drive(1'b1, 4'b0000, 1'b0);
    relock();
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset lk=%0b ec=%0d expected lk=1 ec=1", locked, err_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err_count !== 8'd0 || index !== 2'd0 || onehot_ok !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset lk=%0b ec=%0d idx=%0d ok=%0b expected all 0", locked, err_count, index, onehot_ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap_hold();
    test_locked_errors();
    test_acquire();
    test_counter_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_counter_monitor.md
Name: ring_counter_monitor

Overview:
- Receive-side checker and decoder for the N-bit one-hot ring code produced by the team's ring counters.
- Samples the ring code, checks that it is one-hot and that it steps correctly from sample to sample, and decodes it to a binary index.
- Runs a lock state machine and counts step errors so downstream logic can trust or flag the ring sequence.

Parameters:
- N, 4, ring width in bits; N >= 2.
- LOCK_CNT, 3, number of consecutive correct steps required to declare lock; >= 1.
- ERR_W, 8, width of the saturating error counter.
- IW = $clog2(N), derived localparam, index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; ring_in is evaluated only on edges where en=1.
- ring_in  input  N  ring code under test.
- clr_err  input  1  synchronous clear of err_count.
- index  output  IW  bit position of the set bit in the last valid sample.
- onehot_ok  output  1  last sample was exactly one-hot.
- locked  output  1  FSM is in LOCKED.
- step_err  output  1  one-cycle pulse on a detected error while LOCKED.
- err_count  output  ERR_W  saturating count of step errors.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=UNLOCKED; prev=0; good_cnt=0.
  - index=0, onehot_ok=0, locked=0, step_err=0, err_count=0.
- All outputs are registered and update on the rising edge where en=1, one-cycle latency.
- With en=0: state, prev, index, onehot_ok and err_count hold; step_err=0.
- Validity: a sample is valid when exactly one bit of ring_in is set.
- Expected step: exp = {prev[0], prev[N-1:1]}, i.e. rotate right, so 1000->0100->0010->0001->1000. The wrap from 0001 to 1000 is a legal step.
- index:
  - On a valid sample, index = position of the set bit (1000 -> 3, 0001 -> 0).
  - On an invalid sample, index holds and onehot_ok=0.
- prev is loaded with every valid sample. It is not loaded on invalid samples.
- FSM (transitions evaluated only when en=1):
  - UNLOCKED:
    - valid -> ACQUIRE, good_cnt=0.
    - invalid -> stay.
  - ACQUIRE:
    - valid and ring_in==exp -> good_cnt+1; when good_cnt+1==LOCK_CNT -> LOCKED.
    - valid and ring_in!=exp -> stay in ACQUIRE, good_cnt=0 (reseed from the new sample).
    - invalid -> UNLOCKED.
  - LOCKED:
    - valid and ring_in==exp -> stay.
    - invalid, or ring_in!=exp -> UNLOCKED, step_err=1 for one cycle, err_count+1.
- Errors while UNLOCKED or ACQUIRE are not counted; step_err stays 0.
- err_count:
  - Saturates at 2^ERR_W-1.
  - clr_err=1 forces err_count=0 on that edge and takes priority over a simultaneous increment. The step_err pulse still occurs.
  - clr_err acts regardless of en.
- locked is high exactly while state==LOCKED. It falls on the same edge that raises step_err.
- Reset mid-operation returns immediately to the reset values; no partial lock is retained.

Test Plan (N=4, LOCK_CNT=3, ERR_W=8):
1. Reset: assert rst_n=0 between edges -> all outputs 0 immediately, without waiting for a clock edge. Release, then drive en=0 with ring_in=1000 -> outputs unchanged.
2. Lock acquisition: en=1, feed 1000,0100,0010,0001 on consecutive edges -> index 3,2,1,0, onehot_ok=1 throughout. locked rises on the edge that samples 0001 (third correct step), not earlier.
3. Wrap and hold: while locked, feed 1000, then en=0 for 3 cycles, then 0100 -> locked stays 1, index 3 then 2, step_err=0, err_count=0.
4. Errors while locked:
   - With prev=0100, feed 0001 (skipped step) -> step_err pulse, err_count=1, locked=0, index=0.
   - Relock, then feed 0110 -> step_err pulse, err_count=2, onehot_ok=0, index holds.
5. ACQUIRE reseed and non-counting:
   - From UNLOCKED, feed 1000,0010 -> state stays ACQUIRE with good_cnt=0, err_count unchanged.
   - Then feed 0001,1000,0100 -> locked=1.
   - A 0000 sample during ACQUIRE -> back to UNLOCKED, no step_err.
6. Counter edges and mid-operation reset:
   - Force 255 errors, then one more -> err_count stays 255.
   - clr_err coincident with an error -> err_count=0, step_err=1.
   - rst_n low while LOCKED -> locked=0, err_count=0 immediately.
